// File: rtl/synaptic_update_ctrl_pkg.sv
// Definitions shared with the synaptic core: group-count derivation and the
// training-sweep state encoding.
package synaptic_update_ctrl_pkg;

  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_RD   = 3'd1;
  localparam logic [2:0] ENC_WAIT = 3'd2;
  localparam logic [2:0] ENC_WR   = 3'd3;
  localparam logic [2:0] ENC_FIN  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ENC_IDLE,
    ST_RD   = ENC_RD,
    ST_WAIT = ENC_WAIT,
    ST_WR   = ENC_WR,
    ST_FIN  = ENC_FIN
  } sweep_state_t;

  // Number of SRAM words per pre-neuron row (post neurons packed per word).
  function automatic int calc_groups(input int out_n, input int par);
    return out_n / par;
  endfunction

endpackage

// File: rtl/syn_sweep_counter.sv
// Nested pre/grp sweep counter. The linear word address pre*GROUPS+grp is kept
// as its own incrementing register, so no multiplier is needed.
module syn_sweep_counter
  import synaptic_update_ctrl_pkg::*;
#(
  parameter int PRE_N  = 784,
  parameter int GROUPS = 64,
  parameter int PRE_W  = 10,
  parameter int GRP_W  = 10,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [PRE_W-1:0]  pre,
  output logic [GRP_W-1:0]  grp,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  logic grp_wrap;

  assign grp_wrap = (grp == GRP_LAST);
  assign last     = grp_wrap && (pre == PRE_LAST);

  // Advancing past the last pair wraps everything to zero, ready for the next sweep.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pre  <= '0;
      grp  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last) begin
        pre  <= '0;
        grp  <= '0;
        addr <= '0;
      end else begin
        addr <= addr + 1'b1;
        if (grp_wrap) begin
          grp <= '0;
          pre <= pre + 1'b1;
        end else begin
          grp <= grp + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/synaptic_update_ctrl.sv
// Training-pass sequencer: sweeps every synaptic word as RD/WAIT/WR triplets on
// the weight and gradient SRAMs, and forwards inference reads while idle.
module synaptic_update_ctrl
  import synaptic_update_ctrl_pkg::*;
#(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            IS_TRAIN,
  input  logic                            START,
  input  logic                            INF_REQ,
  input  logic [SYN_ARRAY_ADDR_WIDTH-1:0] INF_ADDR,
  output logic                            INF_GNT,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            CTRL_SYNARRAY_CS,
  output logic                            CTRL_SYNARRAY_WE,
  output logic                            CTRL_GRAD_ARRAY_CS,
  output logic                            CTRL_GRAD_ARRAY_WE,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_GRAD_ARRAY_ADDR,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  output logic                            CTRL_TREF_EVENT
);

  localparam int G = calc_groups(OUTPUT_NEURON, POST_NEUR_PARALLEL);

  sweep_state_t state, state_next;

  logic                            cnt_clear;
  logic                            cnt_advance;
  logic                            cnt_last;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]  cnt_pre;
  logic [POST_NEUR_ADDR_WIDTH-1:0] cnt_grp;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] cnt_addr;
  logic [POST_NEUR_ADDR_WIDTH-1:0] post_base;

  syn_sweep_counter #(
    .PRE_N  (INPUT_NEURON),
    .GROUPS (G),
    .PRE_W  (PRE_NEUR_ADDR_WIDTH),
    .GRP_W  (POST_NEUR_ADDR_WIDTH),
    .ADDR_W (SYN_ARRAY_ADDR_WIDTH)
  ) u_counter (
    .clk     (CLK),
    .rst     (RST),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .pre     (cnt_pre),
    .grp     (cnt_grp),
    .addr    (cnt_addr),
    .last    (cnt_last)
  );

  assign post_base = POST_NEUR_ADDR_WIDTH'(cnt_grp * POST_NEUR_PARALLEL);

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Inference handshake: INF_REQ is a request valid for the current cycle only;
  // INF_GNT is its same-cycle ready. The read is issued exactly in cycles where
  // both are high, which only happens in IDLE with no training start pending.
  always_comb begin
    state_next               = state;
    cnt_clear                = 1'b0;
    cnt_advance              = 1'b0;
    INF_GNT                  = 1'b0;
    BUSY                     = 1'b0;
    DONE                     = 1'b0;
    CTRL_SYNARRAY_CS         = 1'b0;
    CTRL_SYNARRAY_WE         = 1'b0;
    CTRL_GRAD_ARRAY_CS       = 1'b0;
    CTRL_GRAD_ARRAY_WE       = 1'b0;
    CTRL_SYNARRAY_ADDR       = '0;
    CTRL_GRAD_ARRAY_ADDR     = '0;
    CTRL_PRE_NEURON_ADDRESS  = '0;
    CTRL_POST_NEURON_ADDRESS = '0;
    CTRL_TREF_EVENT          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (START && IS_TRAIN) begin
          state_next = ST_RD;
          cnt_clear  = 1'b1;
        end else if (INF_REQ) begin
          INF_GNT            = 1'b1;
          CTRL_SYNARRAY_CS   = 1'b1;
          CTRL_SYNARRAY_ADDR = INF_ADDR;
        end
      end

      ST_RD: begin
        BUSY                     = 1'b1;
        CTRL_SYNARRAY_CS         = 1'b1;
        CTRL_GRAD_ARRAY_CS       = 1'b1;
        CTRL_SYNARRAY_ADDR       = cnt_addr;
        CTRL_GRAD_ARRAY_ADDR     = cnt_addr;
        CTRL_PRE_NEURON_ADDRESS  = cnt_pre;
        CTRL_POST_NEURON_ADDRESS = post_base;
        state_next               = ST_WAIT;
      end

      // SRAMs deselected while read data and spike counts settle.
      ST_WAIT: begin
        BUSY                     = 1'b1;
        CTRL_SYNARRAY_ADDR       = cnt_addr;
        CTRL_GRAD_ARRAY_ADDR     = cnt_addr;
        CTRL_PRE_NEURON_ADDRESS  = cnt_pre;
        CTRL_POST_NEURON_ADDRESS = post_base;
        state_next               = ST_WR;
      end

      ST_WR: begin
        BUSY                     = 1'b1;
        CTRL_SYNARRAY_CS         = 1'b1;
        CTRL_SYNARRAY_WE         = 1'b1;
        CTRL_GRAD_ARRAY_CS       = 1'b1;
        CTRL_GRAD_ARRAY_WE       = 1'b1;
        CTRL_SYNARRAY_ADDR       = cnt_addr;
        CTRL_GRAD_ARRAY_ADDR     = cnt_addr;
        CTRL_PRE_NEURON_ADDRESS  = cnt_pre;
        CTRL_POST_NEURON_ADDRESS = post_base;
        CTRL_TREF_EVENT          = 1'b1;
        cnt_advance              = 1'b1;
        state_next               = cnt_last ? ST_FIN : ST_RD;
      end

      ST_FIN: begin
        DONE       = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// Directed-plus-random bench for synaptic_update_ctrl in the small
// configuration (3 pre neurons, 8 post neurons, 4 per word, 2 groups).
module tb_synaptic_update_ctrl;

  localparam int IN_N  = 3;
  localparam int OUT_N = 8;
  localparam int PAR   = 4;
  localparam int G     = OUT_N / PAR;
  localparam int WORDS = IN_N * G;
  localparam int AW    = 16;
  localparam int PW    = 10;
  localparam int QW    = 10;

  logic          clk = 1'b0;
  logic          rst, is_train, start, inf_req;
  logic [AW-1:0] inf_addr;
  logic          inf_gnt, busy, done;
  logic          syn_cs, syn_we, grad_cs, grad_we;
  logic [AW-1:0] syn_addr, grad_addr;
  logic [PW-1:0] pre_addr;
  logic [QW-1:0] post_addr;
  logic          tref;

  always #5 clk = ~clk;

  synaptic_update_ctrl #(
    .INPUT_NEURON         (IN_N),
    .OUTPUT_NEURON        (OUT_N),
    .POST_NEUR_PARALLEL   (PAR),
    .SYN_ARRAY_ADDR_WIDTH (AW),
    .PRE_NEUR_ADDR_WIDTH  (PW),
    .POST_NEUR_ADDR_WIDTH (QW)
  ) dut (
    .CLK                      (clk),
    .RST                      (rst),
    .IS_TRAIN                 (is_train),
    .START                    (start),
    .INF_REQ                  (inf_req),
    .INF_ADDR                 (inf_addr),
    .INF_GNT                  (inf_gnt),
    .BUSY                     (busy),
    .DONE                     (done),
    .CTRL_SYNARRAY_CS         (syn_cs),
    .CTRL_SYNARRAY_WE         (syn_we),
    .CTRL_GRAD_ARRAY_CS       (grad_cs),
    .CTRL_GRAD_ARRAY_WE       (grad_we),
    .CTRL_SYNARRAY_ADDR       (syn_addr),
    .CTRL_GRAD_ARRAY_ADDR     (grad_addr),
    .CTRL_PRE_NEURON_ADDRESS  (pre_addr),
    .CTRL_POST_NEURON_ADDRESS (post_addr),
    .CTRL_TREF_EVENT          (tref)
  );

  int n_cmp = 0;
  int n_err = 0;

  // SRAM contents, read registers and expected contents
  logic [31:0] wmem [WORDS];
  logic [31:0] gmem [WORDS];
  logic [31:0] exp_w [WORDS];
  logic [31:0] exp_g [WORDS];
  logic [31:0] w_rdata, g_rdata;

  // per-sweep observation log
  bit  log_en;
  int  cyc, busy_cyc, done_cyc, done_idx, first_busy_idx, tref_cyc, tref_bad;
  int  gnt_busy, syn_cs_busy, grad_cs_busy, addr_mismatch;
  logic [AW-1:0] wr_addr_q[$];
  logic [AW-1:0] gwr_addr_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [PW-1:0] wr_pre_q[$];
  logic [QW-1:0] wr_post_q[$];
  logic [AW-1:0] exp_q[$];

  function automatic logic [31:0] byte_inc(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = v[b*8 +: 8] + 8'd1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {4'd0, syn_cs, syn_we, grad_cs, grad_we, syn_addr, grad_addr,
            pre_addr, post_addr, inf_gnt, busy, done, tref};
  endfunction

  task automatic clear_log();
    cyc = 0; busy_cyc = 0; done_cyc = 0; done_idx = -1; first_busy_idx = -1;
    tref_cyc = 0; tref_bad = 0; gnt_busy = 0; syn_cs_busy = 0; grad_cs_busy = 0;
    addr_mismatch = 0;
    wr_addr_q.delete(); gwr_addr_q.delete(); rd_addr_q.delete();
    wr_pre_q.delete(); wr_post_q.delete();
  endtask

  // Called mid-cycle: applies the SRAM effect of this cycle and logs it.
  task automatic observe();
    if (syn_cs && syn_we && syn_addr < WORDS) wmem[syn_addr] = byte_inc(w_rdata);
    if (grad_cs && grad_we && grad_addr < WORDS) gmem[grad_addr] = g_rdata + 32'd1;
    if (syn_cs && !syn_we && syn_addr < WORDS) w_rdata = wmem[syn_addr];
    if (grad_cs && !grad_we && grad_addr < WORDS) g_rdata = gmem[grad_addr];
    if (log_en) begin
      if (busy) begin
        busy_cyc++;
        if (first_busy_idx < 0) first_busy_idx = cyc;
        if (inf_gnt) gnt_busy++;
        if (syn_cs) syn_cs_busy++;
        if (grad_cs) grad_cs_busy++;
        if ((syn_cs || grad_cs) && syn_addr !== grad_addr) addr_mismatch++;
        if (syn_cs && !syn_we) rd_addr_q.push_back(syn_addr);
      end
      if (done) begin done_cyc++; done_idx = cyc; end
      if (tref) begin
        tref_cyc++;
        if (!(syn_cs && syn_we && grad_cs && grad_we)) tref_bad++;
      end
      if (syn_cs && syn_we) begin
        wr_addr_q.push_back(syn_addr);
        wr_pre_q.push_back(pre_addr);
        wr_post_q.push_back(post_addr);
      end
      if (grad_cs && grad_we) gwr_addr_q.push_back(grad_addr);
      cyc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input bit with_inf);
    start = 1'b1; is_train = 1'b1; inf_req = with_inf; inf_addr = 16'd5;
    @(negedge clk);
    if (with_inf) begin
      check("start_vs_inf_gnt", inf_gnt, 0);
      check("start_vs_inf_cs", syn_cs, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0; inf_req = 1'b0;
  endtask

  // One sweep with optional noise: random inference requests, a second START
  // and IS_TRAIN dropping partway through.
  task automatic run_sweep(input bit noisy);
    clear_log();
    start_pulse(noisy);
    log_en = 1'b1;
    for (int k = 0; k < 100 && done_cyc == 0; k++) begin
      if (noisy) begin
        inf_req  = 1'($urandom_range(0, 1));
        inf_addr = 16'($urandom_range(0, WORDS - 1));
        start    = (k == 7);
        is_train = (k < 10);
      end
      tick();
    end
    inf_req = 1'b0; start = 1'b0; is_train = 1'b1;
    repeat (3) tick();
    log_en = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      exp_w[i] = byte_inc(exp_w[i]);
      exp_g[i] = exp_g[i] + 32'd1;
    end
  endtask

  task automatic verify_sweep();
    exp_q.delete();
    for (int p = 0; p < IN_N; p++)
      for (int g = 0; g < G; g++) exp_q.push_back(AW'(p * G + g));
    check("busy_cycles", busy_cyc, 3 * WORDS);
    check("done_pulses", done_cyc, 1);
    check("done_index", done_idx, 3 * WORDS);
    check("first_rd_latency", first_busy_idx, 0);
    check("tref_cycles", tref_cyc, WORDS);
    check("tref_without_we", tref_bad, 0);
    check("gnt_while_busy", gnt_busy, 0);
    check("syn_cs_cycles", syn_cs_busy, 2 * WORDS);
    check("grad_cs_cycles", grad_cs_busy, 2 * WORDS);
    check("grad_addr_follows", addr_mismatch, 0);
    check("write_count", wr_addr_q.size(), WORDS);
    check("grad_write_count", gwr_addr_q.size(), WORDS);
    check("read_count", rd_addr_q.size(), WORDS);
    for (int i = 0; i < WORDS; i++) begin
      if (i < wr_addr_q.size()) begin
        check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], exp_q[i]);
        check($sformatf("wr_pre[%0d]", i), wr_pre_q[i], i / G);
        check($sformatf("wr_post[%0d]", i), wr_post_q[i], (i % G) * PAR);
      end
      if (i < gwr_addr_q.size()) check($sformatf("grad_wr_addr[%0d]", i), gwr_addr_q[i], exp_q[i]);
      if (i < rd_addr_q.size()) check($sformatf("rd_addr[%0d]", i), rd_addr_q[i], exp_q[i]);
      check($sformatf("wmem[%0d]", i), wmem[i], exp_w[i]);
      check($sformatf("gmem[%0d]", i), gmem[i], exp_g[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; is_train = 1'b0; start = 1'b0; inf_req = 1'b0; inf_addr = '0;
    log_en = 1'b0; w_rdata = '0; g_rdata = '0;
    clear_log();
    for (int i = 0; i < WORDS; i++) begin
      wmem[i] = $urandom;
      gmem[i] = $urandom;
    end
    wmem[3] = 32'h01020304;
    for (int i = 0; i < WORDS; i++) begin
      exp_w[i] = wmem[i];
      exp_g[i] = gmem[i];
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_outputs", all_outputs(), 64'd0);

    // inference pass-through in IDLE
    for (int n = 0; n < 4; n++) begin
      inf_req  = 1'b1;
      inf_addr = (n == 0) ? 16'd5 : 16'($urandom_range(0, 16'hffff));
      @(negedge clk);
      check("inf_gnt", inf_gnt, 1);
      check("inf_cs", {syn_cs, syn_we, grad_cs}, 3'b100);
      check("inf_addr", syn_addr, inf_addr);
      @(posedge clk);
      #1;
    end
    inf_req = 1'b0;

    // full sweep with arbitration, mid-sweep starts and inference noise
    run_sweep(1'b1);
    verify_sweep();
    check("word3_rmw", wmem[3], 32'h02030405);

    // START with IS_TRAIN low is ignored
    clear_log();
    is_train = 1'b0; start = 1'b1;
    log_en = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    log_en = 1'b0;
    check("untrained_start_busy", busy_cyc, 0);
    check("untrained_start_done", done_cyc, 0);

    // reset during the WR of address 2 abandons the sweep
    start_pulse(1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      observe();
      if (syn_cs && syn_we && syn_addr == 16'd2) begin
        found = 1'b1;
        rst = 1'b1;
      end
      @(posedge clk);
      #1;
      if (found) break;
    end
    check("abort_point_reached", found, 1);
    check("abort_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      exp_w[i] = byte_inc(exp_w[i]);
      exp_g[i] = exp_g[i] + 32'd1;
    end
    tick();
    check("post_abort_idle", all_outputs(), 64'd0);

    // fresh sweep restarts from address 0
    run_sweep(1'b0);
    verify_sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/synaptic_update_ctrl.md
# synaptic_update_ctrl

Sequencer for the synaptic core's training pass. After each training sample it sweeps every synaptic word and drives the weight and gradient SRAMs as read-wait-write triplets. It supplies the pre/post neuron addresses so the parallel FF-STDP update units see matching spike counts. When idle it passes inference read requests through to the weight SRAM.

## Interface
Parameters:
- INPUT_NEURON, 784: number of pre-synaptic neurons.
- OUTPUT_NEURON, 256: number of post-synaptic neurons.
- POST_NEUR_PARALLEL, 4: post neurons per SRAM word.
- SYN_ARRAY_ADDR_WIDTH, 16: weight/gradient SRAM address width.
- PRE_NEUR_ADDR_WIDTH, 10: pre-neuron index width.
- POST_NEUR_ADDR_WIDTH, 10: post-neuron index width.

Ports:
- CLK  in  1  clock; one clock domain.
- RST  in  1  reset, synchronous, active-high.
- IS_TRAIN  in  1  training mode; START is ignored when low.
- START  in  1  one-cycle pulse: begin an update sweep.
- INF_REQ  in  1  inference read request to the weight SRAM.
- INF_ADDR  in  SYN_ARRAY_ADDR_WIDTH  inference read address.
- INF_GNT  out  1  inference request accepted this cycle.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle pulse: sweep finished.
- CTRL_SYNARRAY_CS / CTRL_SYNARRAY_WE  out  1 each  weight SRAM select / write.
- CTRL_GRAD_ARRAY_CS / CTRL_GRAD_ARRAY_WE  out  1 each  gradient SRAM select / write.
- CTRL_SYNARRAY_ADDR  out  SYN_ARRAY_ADDR_WIDTH  weight SRAM address.
- CTRL_GRAD_ARRAY_ADDR  out  SYN_ARRAY_ADDR_WIDTH  gradient SRAM address; always equals CTRL_SYNARRAY_ADDR during a sweep.
- CTRL_PRE_NEURON_ADDRESS  out  PRE_NEUR_ADDR_WIDTH  current pre index.
- CTRL_POST_NEURON_ADDRESS  out  POST_NEUR_ADDR_WIDTH  post base index = grp*POST_NEUR_PARALLEL.
- CTRL_TREF_EVENT  out  1  update-enable for the FF-STDP units; high in the write cycle only.

## Operation
- Derived constant: G = OUTPUT_NEURON/POST_NEUR_PARALLEL.
- Address mapping: addr = pre*G + grp. Loop order is grp inner (0..G-1), pre outer (0..INPUT_NEURON-1).
- State machine: IDLE, RD, WAIT, WR, FIN.
- IDLE:
  - START & IS_TRAIN goes to RD with pre=0, grp=0.
  - Otherwise, INF_REQ gives CTRL_SYNARRAY_CS=1, WE=0, ADDR=INF_ADDR, INF_GNT=1.
  - START & IS_TRAIN in the same cycle as INF_REQ: START wins and INF_GNT=0.
- RD: both SRAMs CS=1, WE=0, address = current addr.
- WAIT: CS=0. SRAM data plus spike counts settle.
- WR:
  - Both SRAMs CS=1, WE=1, same address; CTRL_TREF_EVENT=1.
  - Then advance grp. On wrap (grp=G-1), set grp=0 and pre+1.
  - If (pre,grp) was the last pair, go to FIN; otherwise go to RD.
- FIN: DONE=1 for one cycle, then IDLE.
- Pre/post neuron address outputs hold the current pair through RD, WAIT and WR.
- BUSY=1 in RD, WAIT and WR; 0 in IDLE and FIN.
- START while BUSY: ignored. INF_REQ while not IDLE: INF_GNT=0, no SRAM access.
- START with IS_TRAIN=0: ignored, no DONE.
- IS_TRAIN falling mid-sweep has no effect; the sweep completes.
- RST at any time: next cycle is IDLE with counters 0. Every output is 0: CS, WE, addresses, INF_GNT, BUSY, DONE, CTRL_TREF_EVENT. A partial sweep is abandoned.

## Timing
- SRAM and control outputs are combinational decodes of state and counters (counters registered). INF_GNT, CS and ADDR are combinational from INF_REQ in IDLE, so an inference read has the SRAM's 1-cycle read latency.
- Sweep length is 3*INPUT_NEURON*G cycles from the first RD to the last WR. DONE follows 1 cycle later. Defaults: 150528 cycles.
- The first RD is in the cycle after the START pulse.
- Read data is valid in WAIT and WR. The write in WR uses data read in RD.

## Structure
- Shared package (with synaptic core): the G derivation and the state encoding localparams (IDLE/RD/WAIT/WR/FIN).
- One natural sub-module, `syn_sweep_counter`: a nested pre/grp counter with clear, advance, last flag and address output addr = pre*G + grp, built as an incrementing register rather than a multiplier.

## Test plan
Small configuration for all scenarios: INPUT_NEURON=3, OUTPUT_NEURON=8, POST_NEUR_PARALLEL=4, so G=2.
- Full sweep: START with IS_TRAIN=1.
  - Write addresses come out in order 0,1,2,3,4,5.
  - POST address sequence is 0,4,0,4,0,4; PRE sequence is 0,0,1,1,2,2.
  - 18 BUSY cycles, then DONE pulses once.
- Read-modify-write: preload weight word 3 with 0x01020304 and use a stub update (+1 per byte). After the sweep, word 3 = 0x02030405; the gradient SRAM is written at the same addresses.
- Arbitration: INF_REQ with INF_ADDR=5 in IDLE gives INF_GNT=1 and CS=1 at address 5. INF_REQ in the same cycle as START gives INF_GNT=0. INF_REQ mid-sweep gives INF_GNT=0 and the access pattern is unchanged.
- Ignored starts: START with IS_TRAIN=0 gives no BUSY and no DONE. A second START mid-sweep leaves the sweep length at 18 cycles.
- Reset mid-sweep: RST during the WR of address 2 puts all outputs at 0 the next cycle. A fresh START restarts at address 0.
- CTRL_TREF_EVENT is high exactly 6 cycles per sweep, each coinciding with WE=1.
